// File: rtl/hard_mem_1rw_rv_adapter_pkg.sv
// Shared types and helpers for the single-port 1rw SRAM ready/valid adapters.
`ifndef HARD_MEM_WIDTH
`define HARD_MEM_WIDTH 64
`endif
`ifndef HARD_MEM_ELS
`define HARD_MEM_ELS 512
`endif

package hard_mem_1rw_rv_adapter_pkg;

  localparam int unsigned hm_width_lp      = `HARD_MEM_WIDTH;
  localparam int unsigned hm_els_lp        = `HARD_MEM_ELS;
  localparam int unsigned hm_addr_width_lp = $clog2(hm_els_lp);
  localparam int unsigned hm_mask_width_lp = hm_width_lp >> 3;

  // Upstream request payload shared by every 1rw adapter
  typedef struct packed {
    logic                        w;
    logic [hm_addr_width_lp-1:0] addr;
    logic [hm_width_lp-1:0]      data;
    logic [hm_mask_width_lp-1:0] write_mask;
  } hard_mem_req_s;

  // A new read may be accepted only if its response is guaranteed a FIFO slot
  function automatic logic resp_credit_ok(input logic [1:0] count, input logic pending);
    return (count == 2'd0) || ((count == 2'd1) && !pending);
  endfunction

endpackage

// File: rtl/hard_mem_resp_fifo_2.sv
// Two-entry response FIFO holding read data the downstream has not yet taken.
module hard_mem_resp_fifo_2 #(
  parameter int unsigned width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enq_v,
  input  logic [width_p-1:0] enq_data,
  input  logic               deq_yumi,
  output logic               head_v,
  output logic [width_p-1:0] head_data,
  output logic [1:0]         count
);

  logic [width_p-1:0] mem_r [2];
  logic               wr_ptr_r;
  logic               rd_ptr_r;
  logic [1:0]         count_r;

  // Pointers and occupancy; enqueue and dequeue may happen together
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (enq_v)    wr_ptr_r <= ~wr_ptr_r;
      if (deq_yumi) rd_ptr_r <= ~rd_ptr_r;
      count_r <= count_r + 2'(enq_v) - 2'(deq_yumi);
    end
  end

  // Data storage needs no reset; occupancy qualifies it
  always_ff @(posedge clk_i) begin
    if (enq_v) mem_r[wr_ptr_r] <= enq_data;
  end

  assign head_v    = (count_r != 2'd0);
  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Catch any enqueue into a full FIFO or dequeue from an empty one
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(enq_v && (count_r == 2'd2))) else $error("resp fifo overflow");
      assert (!(deq_yumi && (count_r == 2'd0))) else $error("resp fifo underflow");
    end
  end

endmodule

// File: rtl/hard_mem_1rw_rv_adapter.sv
// Ready/valid front-end for a 1rw byte-masked SRAM with in-order read responses.
module hard_mem_1rw_rv_adapter
  import hard_mem_1rw_rv_adapter_pkg::*;
#(
  parameter  int unsigned width_p             = 64,
  parameter  int unsigned els_p               = 512,
  localparam int unsigned addr_width_lp       = $clog2(els_p),
  localparam int unsigned write_mask_width_lp = width_p >> 3
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  output logic                           ready_o,
  input  logic                           w_i,
  input  logic [addr_width_lp-1:0]       addr_i,
  input  logic [width_p-1:0]             data_i,
  input  logic [write_mask_width_lp-1:0] write_mask_i,
  output logic                           v_o,
  output logic [width_p-1:0]             data_o,
  input  logic                           yumi_i,
  output logic                           mem_v_o,
  output logic                           mem_w_o,
  output logic [addr_width_lp-1:0]       mem_addr_o,
  output logic [width_p-1:0]             mem_data_o,
  output logic [write_mask_width_lp-1:0] mem_write_mask_o,
  input  logic [width_p-1:0]             mem_data_i
);

  logic               pending_r;
  logic               accept_rd;
  logic               enq_v;
  logic               deq_yumi;
  logic               head_v;
  logic [width_p-1:0] head_data;
  logic [1:0]         count;

  // Credit gate: registers only, forced low while reset is held
  assign ready_o   = !reset_i && resp_credit_ok(count, pending_r);
  assign accept_rd = v_i && ready_o && !w_i;

  // Requests pass straight to the memory pins in the accept cycle
  assign mem_v_o          = v_i && ready_o;
  assign mem_w_o          = w_i;
  assign mem_addr_o       = addr_i;
  assign mem_data_o       = data_i;
  assign mem_write_mask_o = write_mask_i;

  // Read issued last cycle: memory data is on mem_data_i this cycle
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) pending_r <= 1'b0;
    else         pending_r <= accept_rd;
  end

  // Response mux: queued head has priority, otherwise bypass fresh memory data
  always_comb begin
    v_o      = pending_r || head_v;
    data_o   = head_v ? head_data : mem_data_i;
    deq_yumi = yumi_i && head_v;
    enq_v    = pending_r && !(yumi_i && !head_v);
  end

  hard_mem_resp_fifo_2 #(.width_p(width_p)) resp_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .enq_v     (enq_v),
    .enq_data  (mem_data_i),
    .deq_yumi  (deq_yumi),
    .head_v    (head_v),
    .head_data (head_data),
    .count     (count)
  );

  // Downstream must not consume when nothing is offered
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o)) else $error("yumi_i asserted while v_o=0");
    end
  end

endmodule

// File: tb/tb_hard_mem_1rw_rv_adapter.sv
// Scoreboard bench for hard_mem_1rw_rv_adapter with a behavioural 512x64 SRAM.
`timescale 1ns/1ps
module tb_hard_mem_1rw_rv_adapter;

  localparam int unsigned W = 64;
  localparam int unsigned A = 9;
  localparam int unsigned M = 8;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         v_i, ready_o, w_i;
  logic [A-1:0] addr_i;
  logic [W-1:0] data_i;
  logic [M-1:0] write_mask_i;
  logic         v_o;
  logic [W-1:0] data_o;
  logic         yumi_i;
  logic         mem_v_o, mem_w_o;
  logic [A-1:0] mem_addr_o;
  logic [W-1:0] mem_data_o;
  logic [M-1:0] mem_write_mask_o;
  logic [W-1:0] mem_data_i;

  int n_checks = 0;
  int n_fail   = 0;
  int yumi_mode = 0; // 0 hold off, 1 always, 2 random
  logic [W-1:0] exp_q [$];
  logic [W-1:0] mem_model [512];
  logic [W-1:0] ref_mem [16];

  always #5 clk = ~clk;

  hard_mem_1rw_rv_adapter dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .v_i              (v_i),
    .ready_o          (ready_o),
    .w_i              (w_i),
    .addr_i           (addr_i),
    .data_i           (data_i),
    .write_mask_i     (write_mask_i),
    .v_o              (v_o),
    .data_o           (data_o),
    .yumi_i           (yumi_i),
    .mem_v_o          (mem_v_o),
    .mem_w_o          (mem_w_o),
    .mem_addr_o       (mem_addr_o),
    .mem_data_o       (mem_data_o),
    .mem_write_mask_o (mem_write_mask_o),
    .mem_data_i       (mem_data_i)
  );

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] d,
                                         input logic [M-1:0] m);
    logic [W-1:0] r = old;
    for (int b = 0; b < M; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [W-1:0] pat(input int i);
    return {32'hC0DE0000 + 32'(i), 32'h5A5A0000 + 32'(i * 3)};
  endfunction

  // Behavioural single-port SRAM: one-cycle read latency, byte-masked writes
  always @(posedge clk) begin
    if (mem_v_o) begin
      if (mem_w_o) mem_model[mem_addr_o] <= merge(mem_model[mem_addr_o], mem_data_o, mem_write_mask_o);
      else         mem_data_i <= mem_model[mem_addr_o];
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Downstream consumer: decides yumi just after each rising edge
  always @(posedge clk) begin
    #1;
    case (yumi_mode)
      1:       yumi_i = v_o;
      2:       yumi_i = v_o && ($urandom_range(0, 1) == 1);
      default: yumi_i = 1'b0;
    endcase
  end

  // Monitor: every consumed response must match the oldest expected value
  always @(negedge clk) begin
    if (!reset_i && v_o && yumi_i) begin
      if (exp_q.size() == 0) check("unexpected_response", data_o, 64'hx);
      else                   check("resp_data", data_o, exp_q.pop_front());
    end
  end

  task automatic req(input logic w, input logic [A-1:0] a, input logic [W-1:0] d,
                     input logic [M-1:0] m, input logic [W-1:0] e, output int waits);
    waits = 0;
    v_i = 1'b1; w_i = w; addr_i = a; data_i = d; write_mask_i = m;
    while (!ready_o && waits < 100) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!ready_o) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      if (!w) exp_q.push_back(e);
      @(posedge clk); #1;
    end
    v_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int wt;
    int seen;
    reset_i = 1'b1; v_i = 1'b1; w_i = 1'b0; addr_i = '0; data_i = '0;
    write_mask_i = '0; yumi_i = 1'b0; mem_data_i = '0;
    #3;
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_v_o", 64'(v_o), 64'd0);
    check("rst_mem_v", 64'(mem_v_o), 64'd0);
    v_i = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_i = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", 64'(ready_o), 64'd1);

    // Full write then read with immediate consume: bypass in the next cycle
    yumi_mode = 1;
    req(1'b1, 9'd5, 64'hDEADBEEF_CAFEF00D, 8'hFF, '0, wt);
    req(1'b0, 9'd5, '0, '0, 64'hDEADBEEF_CAFEF00D, wt);
    check("bypass_v", 64'(v_o), 64'd1);
    check("bypass_data", data_o, 64'hDEADBEEF_CAFEF00D);
    drain();

    // Partial byte mask over existing data
    req(1'b1, 9'd7, 64'hAAAAAAAA_BBBBBBBB, 8'hFF, '0, wt);
    req(1'b1, 9'd7, 64'h11111111_22222222, 8'h0F, '0, wt);
    req(1'b0, 9'd7, '0, '0, 64'hAAAAAAAA_22222222, wt);
    drain();

    // Fill 0..15, then 16 back-to-back reads with no stall
    for (int i = 0; i < 16; i++) begin
      req(1'b1, 9'(i), pat(i), 8'hFF, '0, wt);
      ref_mem[i] = pat(i);
    end
    for (int i = 0; i < 16; i++) begin
      req(1'b0, 9'(i), '0, '0, pat(i), wt);
      check("b2b_no_wait", 64'(wt), 64'd0);
    end
    drain();

    // Stall: two reads outstanding close the gate until the consumer returns
    yumi_mode = 0;
    @(posedge clk); #1;
    req(1'b0, 9'd1, '0, '0, pat(1), wt);
    req(1'b0, 9'd2, '0, '0, pat(2), wt);
    check("stall_ready_low", 64'(ready_o), 64'd0);
    @(posedge clk); #1;
    check("stall_ready_low2", 64'(ready_o), 64'd0);
    check("stall_v_o", 64'(v_o), 64'd1);
    check("stall_head", data_o, pat(1));
    yumi_mode = 1;
    req(1'b0, 9'd3, '0, '0, pat(3), wt);
    drain();

    // Reset mid-read: response dropped, memory contents kept
    yumi_mode = 0;
    @(posedge clk); #1;
    req(1'b0, 9'd4, '0, '0, pat(4), wt);
    @(negedge clk); #2;
    reset_i = 1'b1;
    v_i = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_v_o", 64'(v_o), 64'd0);
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_mem_v", 64'(mem_v_o), 64'd0);
    v_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    check("post_rst_ready", 64'(ready_o), 64'd1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (v_o) seen++;
    end
    check("no_resp_after_reset", 64'(seen), 64'd0);
    yumi_mode = 1;
    @(posedge clk); #1;
    req(1'b0, 9'd4, '0, '0, pat(4), wt);
    drain();

    // Random reads/writes on addresses 0..15 with random backpressure
    yumi_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      logic [A-1:0] a;
      logic [W-1:0] d;
      logic [M-1:0] m;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      a = 9'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        d = {$urandom, $urandom};
        m = 8'($urandom);
        ref_mem[a[3:0]] = merge(ref_mem[a[3:0]], d, m);
        req(1'b1, a, d, m, '0, wt);
      end else begin
        req(1'b0, a, '0, '0, ref_mem[a[3:0]], wt);
      end
    end
    yumi_mode = 1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
